joy_shift_reader: RTL and testbench
===================================

JOY_SHIFT_READER -- requirements
Module: joy_shift_reader

Interface
REQ-001 The block SHALL have parameter PORTS, default 2, giving the number of daisy-chained controllers (1..4).
REQ-002 The block SHALL have parameter BITS, default 12, giving the bits per controller (8..16).
REQ-003 The block SHALL have parameter DIV, default 12, giving the clk_sys cycles per joy_clk half-period (2..255).
REQ-004 The block SHALL have parameter GAP, default 64, giving the idle clk_sys cycles between frames (1..4095).
REQ-005 The block SHALL have parameter FILTER, default 1: 1 = two-frame agreement filter on, 0 = update on every frame.
REQ-006 The block SHALL have parameter INVERT, default 1: 1 = joy_data is active-low and is inverted before storage.
REQ-007 clk_sys  input  1  single system clock; all logic on its rising edge.
REQ-008 reset_n  input  1  synchronous, active-low reset.
REQ-009 enable  input  1  level; permits a new frame to start.
REQ-010 joy_data  input  1  serial data from the external shift-register chain.
REQ-011 joy_clk  output  1  shift clock to the chain.
REQ-012 joy_load  output  1  parallel-load strobe, active-low.
REQ-013 joystick  output  PORTS*BITS  filtered button state; port p occupies bits [p*BITS +: BITS].
REQ-014 frame_done  output  1  one-cycle pulse at the end of every frame.
REQ-015 changed  output  1  one-cycle pulse when joystick takes a new value.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT, GAP and CMP.
REQ-017 IDLE: joy_load=1 and joy_clk=0; the FSM SHALL go to LOAD when enable=1.
REQ-018 LOAD: joy_load=0 and joy_clk=0 for exactly 2*DIV cycles, then SHIFT.
REQ-019 SHIFT, per bit: joy_clk=0 for DIV cycles and joy_data sampled on the last low cycle, then joy_clk=1 for DIV cycles.
REQ-020 SHIFT SHALL shift exactly PORTS*BITS bits; the first sampled bit is port 0 bit 0, then ascending bit and port order.
REQ-021 After the last high phase, joy_clk SHALL return to 0 and the FSM SHALL enter GAP for exactly GAP cycles, then CMP.
REQ-022 CMP SHALL last 1 cycle and pulse frame_done, then go to LOAD if enable=1, otherwise IDLE.
REQ-023 Frame length SHALL be 2*DIV + PORTS*BITS*2*DIV + GAP + 1 cycles; with defaults this is 665.
REQ-024 Each sample SHALL be stored as INVERT ? ~joy_data : joy_data.
REQ-025 In CMP with FILTER=1, joystick SHALL load the new frame only when it equals the previous raw frame.
REQ-026 In CMP with FILTER=0, joystick SHALL load every new frame.
REQ-027 The raw-previous register SHALL always be updated in CMP.
REQ-028 changed SHALL pulse in CMP, coincident with frame_done, only when the loaded value differs from the old joystick.
REQ-029 enable deasserted mid-frame SHALL NOT abort the frame; the frame SHALL complete and the FSM then idles.
REQ-030 joystick SHALL hold its last value while idle.
REQ-031 All outputs SHALL be registered, with no combinational path from joy_data or enable to any output.
REQ-032 Counter widths SHALL be $clog2 of their maximum count plus 1; there is no wrap within a phase.

Reset
REQ-033 When reset_n=0 at a clock edge: state=IDLE, joy_clk=0, joy_load=1, joystick=0, raw-previous=0, frame_done=0, changed=0, and all counters=0.
REQ-034 Reset SHALL override any phase, including mid-SHIFT; the partial frame SHALL be discarded and never reach joystick.
REQ-035 After reset_n returns to 1 with enable=1, LOAD SHALL begin on the next cycle.

Structure
REQ-036 Package joy_shift_pkg SHALL hold the state enum and the phase-length width helper constants.
REQ-037 Sub-module joy_tick_gen SHALL provide the DIV-cycle half-period tick: restartable, and reset by reset_n.
REQ-038 The RTL total SHALL be 120-400 lines.

Verification
REQ-039 Default parameters, chain model presenting port0=12'h0FE and port1=12'hFFF raw, FILTER=1: after 2 frames, joystick=24'h000F01 and changed pulses once, at frame 2 CMP.
REQ-040 The same stimulus with FILTER=0 SHALL give joystick=24'h000F01 after frame 1.
REQ-041 Raw data alternating between two values every frame with FILTER=1: joystick stays 0 and changed never pulses.
REQ-042 Bench measurement: joy_load low for 24 cycles, 24 joy_clk rising edges per frame, frame_done period of 665 cycles, sampling 1 cycle before each rise.
REQ-043 reset_n driven low for 1 cycle at bit 10 of SHIFT: outputs return to reset values the next cycle, and joystick is not updated from the partial frame.
REQ-044 enable dropped at bit 5: the frame completes and frame_done pulses once; joy_load then stays 1 and joy_clk stays 0.

Source files
------------

// File: rtl/joy_shift_pkg.sv
// -----------------------------------------------------------------------------
// joy_shift_pkg
// Shared types and helpers for the serial joystick reader.
//   state_t  : FSM state encoding for joy_shift_reader
//   cnt_w()  : width of a counter that must reach max_count without wrapping
//   *_MAX    : legal upper bounds of the block parameters
// -----------------------------------------------------------------------------
package joy_shift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_CMP   = 3'd4
  } state_t;

  localparam int PORTS_MAX = 4;
  localparam int BITS_MAX  = 16;
  localparam int DIV_MAX   = 255;
  localparam int GAP_MAX   = 4095;

  // One spare bit above $clog2 so a phase counter can hold its terminal count
  // even when max_count is an exact power of two.
  function automatic int cnt_w(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage : joy_shift_pkg

// File: rtl/joy_tick_gen.sv
// -----------------------------------------------------------------------------
// joy_tick_gen
// Half-period tick for the joystick shift clock: o_tick is high on every DIV-th
// cycle while i_run is high. The count restarts from zero whenever i_run is low
// or i_restart is high, so every phase starts on a clean boundary.
// Ports:
//   clk_sys   in  system clock
//   reset_n   in  synchronous active-low reset
//   i_run     in  count enable (phase in progress)
//   i_restart in  force the count back to zero
//   o_tick    out last cycle of the current half-period
// -----------------------------------------------------------------------------
module joy_tick_gen
  import joy_shift_pkg::*;
#(
  parameter int DIV = 12
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = cnt_w(DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DIV - 1));
  assign o_tick = i_run && w_last;

  // NOTE: state in always_ff is written only with <=, so every flop sees the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_run || i_restart || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : joy_tick_gen

// File: rtl/joy_shift_reader.sv
// -----------------------------------------------------------------------------
// joy_shift_reader
// Reads PORTS daisy-chained BITS-bit parallel-in/serial-out controllers:
// pulses joy_load low, clocks PORTS*BITS bits out on joy_clk, waits GAP idle
// cycles, then (optionally after a two-frame agreement filter) updates joystick.
// Ports:
//   clk_sys     in  system clock
//   reset_n     in  synchronous active-low reset
//   enable      in  allows a new frame to start
//   joy_data    in  serial data from the chain
//   joy_clk     out shift clock to the chain
//   joy_load    out parallel-load strobe, active-low
//   joystick    out button state, port p at [p*BITS +: BITS]
//   frame_done  out one-cycle pulse at the end of every frame
//   changed     out one-cycle pulse when joystick takes a new value
// -----------------------------------------------------------------------------
module joy_shift_reader
  import joy_shift_pkg::*;
#(
  parameter int PORTS  = 2,
  parameter int BITS   = 12,
  parameter int DIV    = 12,
  parameter int GAP    = 64,
  parameter int FILTER = 1,
  parameter int INVERT = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  joy_data,
  output logic                  joy_clk,
  output logic                  joy_load,
  output logic [PORTS*BITS-1:0] joystick,
  output logic                  frame_done,
  output logic                  changed
);

  localparam int NBITS = PORTS * BITS;
  localparam int BIT_W = cnt_w(NBITS);
  localparam int GAP_W = cnt_w(GAP);

  state_t             r_state, w_next_state;
  logic               r_half, w_half_next;   // 0 = joy_clk low phase, 1 = high
  logic [BIT_W-1:0]   r_bit, w_bit_next;
  logic [GAP_W-1:0]   r_gap, w_gap_next;

  logic               w_tick, w_run, w_restart;
  logic               w_sample, w_cmp_entry, w_new_bit, w_accept;

  logic [NBITS-1:0]   r_shift, r_prev, r_joy;
  logic               r_joy_clk, r_joy_load, r_frame_done, r_changed;

  assign w_run     = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign w_restart = (w_next_state != r_state);

  joy_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .i_run     (w_run),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next_state;
      r_half  <= w_half_next;
      r_bit   <= w_bit_next;
      r_gap   <= w_gap_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. LOAD is two half-periods long; each SHIFT bit is one low
  // half-period followed by one high half-period.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block leaves one unassigned and no latch is inferred.
    w_next_state = r_state;
    w_half_next  = r_half;
    w_bit_next   = r_bit;
    w_gap_next   = r_gap;

    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_tick) begin
          w_half_next = ~r_half;
          if (r_half) w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          w_half_next = ~r_half;
          if (r_half) begin
            if (r_bit == BIT_W'(NBITS - 1)) begin
              w_next_state = ST_GAP;
              w_bit_next   = '0;
            end else begin
              w_bit_next = r_bit + BIT_W'(1);
            end
          end
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_W'(GAP - 1)) begin
          w_next_state = ST_CMP;
          w_gap_next   = '0;
        end else begin
          w_gap_next = r_gap + GAP_W'(1);
        end
      end
      ST_CMP: begin
        w_next_state = enable ? ST_LOAD : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Sample on the last low cycle, i.e. the same edge that raises joy_clk, so
  // the chain has not yet shifted when the bit is captured.
  assign w_sample    = (r_state == ST_SHIFT) && w_tick && !r_half;
  assign w_cmp_entry = (r_state == ST_GAP) && (w_next_state == ST_CMP);
  assign w_new_bit   = (INVERT != 0) ? ~joy_data : joy_data;
  assign w_accept    = (FILTER == 0) || (r_shift == r_prev);

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs. Outputs are registered from the next-state
  // decode so each one lines up with the state it belongs to. The frame
  // decision is taken on the edge into CMP, so joystick, frame_done and
  // changed all become visible together during the CMP cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_joy_clk    <= 1'b0;
      r_joy_load   <= 1'b1;
      r_frame_done <= 1'b0;
      r_changed    <= 1'b0;
      // NOTE: the data registers are reset too: a frame cut short by reset
      // must not leave stale bits that could later match in the filter.
      r_shift      <= '0;
      r_prev       <= '0;
      r_joy        <= '0;
    end else begin
      r_joy_clk    <= (w_next_state == ST_SHIFT) && w_half_next;
      r_joy_load   <= (w_next_state != ST_LOAD);
      r_frame_done <= w_cmp_entry;
      r_changed    <= w_cmp_entry && w_accept && (r_shift != r_joy);

      // First sample ends up in bit 0 after NBITS shifts.
      if (w_sample) r_shift <= {w_new_bit, r_shift[NBITS-1:1]};

      if (w_cmp_entry) begin
        r_prev <= r_shift;
        if (w_accept) r_joy <= r_shift;
      end
    end
  end

  assign joy_clk    = r_joy_clk;
  assign joy_load   = r_joy_load;
  assign joystick   = r_joy;
  assign frame_done = r_frame_done;
  assign changed    = r_changed;

endmodule : joy_shift_reader

// File: tb/tb_joy_shift_reader.sv
// -----------------------------------------------------------------------------
// tb_joy_shift_reader
// Two readers with default parameters, one with FILTER=1 and one with
// FILTER=0, each fed by its own model of a 24-bit active-low shift chain
// that loads on joy_load falling and shifts on joy_clk rising.
// -----------------------------------------------------------------------------
module tb_joy_shift_reader;

  localparam int N      = 24;
  localparam int FRAME  = 665;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] exp_j0;
    logic         exp_ch0;
    logic [N-1:0] exp_j1;
    logic         exp_ch1;
  } vec_t;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [N-1:0] raw;

  logic         joy_data0, joy_clk0, joy_load0, done0, ch0;
  logic [N-1:0] joystick0, sr0;
  logic         joy_data1, joy_clk1, joy_load1, done1, ch1;
  logic [N-1:0] joystick1, sr1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  joy_shift_reader #(.FILTER(1)) u_dut_f1 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .joy_data   (joy_data0),
    .joy_clk    (joy_clk0),
    .joy_load   (joy_load0),
    .joystick   (joystick0),
    .frame_done (done0),
    .changed    (ch0)
  );

  joy_shift_reader #(.FILTER(0)) u_dut_f0 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .joy_data   (joy_data1),
    .joy_clk    (joy_clk1),
    .joy_load   (joy_load1),
    .joystick   (joystick1),
    .frame_done (done1),
    .changed    (ch1)
  );

  // Chain models: bit 0 of raw is presented first; idle fill is 1 (released).
  always @(posedge joy_clk0 or negedge joy_load0)
    if (!joy_load0) sr0 <= raw;
    else            sr0 <= {1'b1, sr0[N-1:1]};
  assign joy_data0 = sr0[0];

  always @(posedge joy_clk1 or negedge joy_load1)
    if (!joy_load1) sr1 <= raw;
    else            sr1 <= {1'b1, sr1[N-1:1]};
  assign joy_data1 = sr1[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs from the current negedge up to the negedge where frame_done is seen.
  task automatic wait_frame(output int cycles, output int lows, output int rises,
                            output int n_c0, output int n_c1, output logic d1,
                            output logic ok);
    logic prev;
    prev = joy_clk0;
    cycles = 0; lows = 0; rises = 0; n_c0 = 0; n_c1 = 0; d1 = 1'b0; ok = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk_sys);
      if (!joy_load0) lows++;
      if (joy_clk0 && !prev) rises++;
      prev = joy_clk0;
      if (ch0) n_c0++;
      if (ch1) n_c1++;
      if (done0) begin
        cycles = c;
        d1     = done1;
        ok     = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rises(input int n, output logic ok);
    logic prev;
    int   seen;
    prev = joy_clk0;
    seen = 0;
    ok   = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk_sys);
      if (joy_clk0 && !prev) seen++;
      prev = joy_clk0;
      if (seen >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_joy_load"}, 32'(joy_load0), 32'd1);
    check({tag, "_joy_clk"},  32'(joy_clk0),  32'd0);
    check({tag, "_joystick"}, 32'(joystick0), 32'd0);
    check({tag, "_joystick_f0"}, 32'(joystick1), 32'd0);
    check({tag, "_frame_done"}, 32'(done0), 32'd0);
    check({tag, "_changed"},  32'(ch0),       32'd0);
  endtask

  vec_t tbl [9];

  initial begin
    int   cyc, lows, rises, nc0, nc1, idle_done, idle_load, idle_clk;
    logic d1, ok;

    tbl[0] = '{24'hA5A5A5, 24'h000000, 1'b0, 24'h5A5A5A, 1'b1};
    tbl[1] = '{24'h123456, 24'h000000, 1'b0, 24'hEDCBA9, 1'b1};
    tbl[2] = '{24'hA5A5A5, 24'h000000, 1'b0, 24'h5A5A5A, 1'b1};
    tbl[3] = '{24'h123456, 24'h000000, 1'b0, 24'hEDCBA9, 1'b1};
    tbl[4] = '{24'hFFF0FE, 24'h000000, 1'b0, 24'h000F01, 1'b1};
    tbl[5] = '{24'hFFF0FE, 24'h000F01, 1'b1, 24'h000F01, 1'b0};
    tbl[6] = '{24'hFFFFFF, 24'h000F01, 1'b0, 24'h000000, 1'b1};
    tbl[7] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b0};
    tbl[8] = '{24'h000000, 24'h000000, 1'b0, 24'hFFFFFF, 1'b1};

    reset_n = 1'b0;
    enable  = 1'b0;
    raw     = tbl[0].raw;
    repeat (3) @(negedge clk_sys);
    check_reset_values("rst");

    // Out of reset with enable low: the reader must stay idle.
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("idle_joy_load", 32'(joy_load0), 32'd1);
    enable = 1'b1;

    for (int i = 0; i < 9; i++) begin
      wait_frame(cyc, lows, rises, nc0, nc1, d1, ok);
      if (!ok) begin
        check("frame_timeout", 32'd0, 32'd1);
        break;
      end
      check($sformatf("f%0d_joystick_f1", i), 32'(joystick0), 32'(tbl[i].exp_j0));
      check($sformatf("f%0d_changed_f1", i),  32'(nc0),       32'(tbl[i].exp_ch0));
      check($sformatf("f%0d_joystick_f0", i), 32'(joystick1), 32'(tbl[i].exp_j1));
      check($sformatf("f%0d_changed_f0", i),  32'(nc1),       32'(tbl[i].exp_ch1));
      check($sformatf("f%0d_load_low", i),    32'(lows),      32'd24);
      check($sformatf("f%0d_clk_rises", i),   32'(rises),     32'd24);
      check($sformatf("f%0d_done_f0", i),     32'(d1),        32'd1);
      if (i > 0) check($sformatf("f%0d_period", i), 32'(cyc), 32'(FRAME));
      raw = tbl[(i + 1) % 9].raw;
    end

    // Reset in the middle of SHIFT.
    raw = 24'h0F0F0F;
    wait_rises(10, ok);
    check("rst_mid_shift_reached", 32'(ok), 32'd1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    check_reset_values("rst_mid");

    // First post-reset frame starts immediately and is a full frame.
    wait_frame(cyc, lows, rises, nc0, nc1, d1, ok);
    check("post_rst_done", 32'(ok), 32'd1);
    check("post_rst_latency", 32'(cyc), 32'(FRAME));
    check("post_rst_rises", 32'(rises), 32'd24);
    check("post_rst_joystick_f1", 32'(joystick0), 32'h000000);
    check("post_rst_changed_f1", 32'(nc0), 32'd0);
    check("post_rst_joystick_f0", 32'(joystick1), 32'hF0F0F0);

    // Enable dropped mid-SHIFT: frame still completes, then idle.
    wait_rises(5, ok);
    check("en_drop_reached", 32'(ok), 32'd1);
    enable = 1'b0;
    wait_frame(cyc, lows, rises, nc0, nc1, d1, ok);
    check("en_drop_done", 32'(ok), 32'd1);
    check("en_drop_rises", 32'(rises), 32'd19);
    check("en_drop_joystick_f1", 32'(joystick0), 32'hF0F0F0);
    check("en_drop_changed_f1", 32'(nc0), 32'd1);

    idle_done = 0; idle_load = 0; idle_clk = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_sys);
      if (done0)      idle_done++;
      if (!joy_load0) idle_load++;
      if (joy_clk0)   idle_clk++;
    end
    check("idle_frame_done", 32'(idle_done), 32'd0);
    check("idle_load_low",   32'(idle_load), 32'd0);
    check("idle_clk_high",   32'(idle_clk),  32'd0);
    check("idle_joystick_hold", 32'(joystick0), 32'hF0F0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_joy_shift_reader
